i2c_cfg_slave: RTL and testbench
================================

Name: i2c_cfg_slave

Overview:
- Write-only I2C slave controller that sequences reception of configuration bytes into the FIR filter coefficient/control register bank.
- Consumes the registered SDA level and the one-cycle event pulses from i2c_detector (start, stop, SCL rise, SCL fall).
- Drives the SDA open-drain pull-down for ACK.
- Emits one-cycle register write strobes with address and data toward the filter configuration registers.

Parameters:
DEV_ADDR, 7'h48, 7-bit I2C device address this slave responds to.
NUM_REGS, 16, number of writable configuration registers (2..256); register pointer width RW = $clog2(NUM_REGS).

Ports:
clk  input  1  system clock; all event inputs are synchronous to it.
rst  input  1  asynchronous active-high reset.
sda_in  input  1  synchronized SDA level, valid when scl_rise_in is high.
start_in  input  1  one-cycle pulse: START or repeated START detected.
stop_in  input  1  one-cycle pulse: STOP detected.
scl_rise_in  input  1  one-cycle pulse: SCL rising edge.
scl_fall_in  input  1  one-cycle pulse: SCL falling edge.
sda_low_out  output  1  1 = pull SDA low (ACK); 0 = release.
cfg_wr_out  output  1  one-cycle register write strobe.
cfg_addr_out  output  RW  register index for the write.
cfg_data_out  output  8  register data for the write.
busy_out  output  1  1 while a transaction is open (START seen, no STOP yet).

Behaviour:
- Reset values: state IDLE; sda_low_out=0; cfg_wr_out=0; cfg_addr_out=0; cfg_data_out=0; busy_out=0; bit counter=0; shift register=0; register pointer=0. Reset mid-transaction aborts immediately and releases SDA.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, DATA, DATA_ACK, IGNORE.
- Event priority in any single cycle: stop_in > start_in > scl_rise_in/scl_fall_in.
- stop_in in any state:
  - next state IDLE; sda_low_out=0 next cycle; busy_out=0.
  - A partially shifted byte is discarded and no write is issued.
- start_in in any state:
  - next state ADDR; bit counter cleared; sda_low_out=0; busy_out=1.
  - The register pointer is kept; it is only loaded by a PTR byte.
- Bit reception in ADDR, PTR and DATA:
  - On scl_rise_in, shift sda_in into the byte register MSB-first and increment the bit counter.
  - The 8th rise completes the byte and sets an ack-pending flag; the state stays put.
- ACK phase:
  - On the first scl_fall_in after byte completion, enter the matching *_ACK state. sda_low_out is registered and asserts the cycle after that fall if the byte is accepted.
  - On the next scl_fall_in (end of 9th clock), sda_low_out deasserts the following cycle and the next state is entered with the bit counter cleared.
  - scl_rise_in during *_ACK (the master sampling ACK) is ignored.
- ADDR byte:
  - Accepted iff byte[7:1]==DEV_ADDR and byte[0]==0 (write). Accepted -> ADDR_ACK (ACK), then PTR.
  - Address mismatch or read bit set -> no ACK (SDA released), then IGNORE.
- PTR byte:
  - Accepted iff value < NUM_REGS. The pointer is loaded with the value, then PTR_ACK (ACK), then DATA.
  - Out of range -> no ACK, pointer unchanged, then IGNORE.
- DATA byte:
  - The cycle after the 8th scl_rise_in: cfg_wr_out=1 for exactly one cycle, cfg_addr_out=pointer, cfg_data_out=byte.
  - Then DATA_ACK (always ACK), then DATA again.
  - Pointer increments after the write and wraps NUM_REGS-1 -> 0.
- cfg_addr_out/cfg_data_out hold their last written values between strobes.
- IGNORE: all SCL events are ignored and SDA stays released until start_in or stop_in.
- IDLE: SCL events are ignored.
- Write latency: cfg_wr_out is high 1 clk after the scl_rise_in pulse of data bit 0 (LSB).

Test Plan:
- START, addr 0x90 (0x48+W), ptr 0x03, data 0xA5, STOP -> ACK on all three 9th clocks; single cfg_wr_out pulse with addr 3, data 0xA5; busy_out 1 from START+1 to STOP+1.
- START, addr 0x40 (mismatch), ptr 0x02, data 0x11 -> sda_low_out stays 0 throughout; no cfg_wr_out.
- START, addr 0x91 (read) -> NACK, IGNORE; subsequent bytes produce no writes until STOP.
- ptr 0x0E, data 0x01, 0x02, 0x03 -> writes to 14, 15, 0 (wrap) with data 1, 2, 3; ptr 0x10 (out of range) -> NACK, no writes.
- Mid-DATA after 5 bits: STOP -> no write, IDLE. Repeated START then a full frame with ptr 5, data 0x3C -> write addr 5 data 0x3C.
- Assert rst while sda_low_out=1 in ADDR_ACK -> sda_low_out=0 and busy_out=0 immediately (async); the next full frame behaves normally.

Source files
------------

// File: rtl/i2c_cfg_slave.sv
// rtl/i2c_cfg_slave.sv - write-only I2C slave loading the FIR configuration register bank
//
// Receives I2C write transactions of the form
//   START, {DEV_ADDR,W}, pointer, data, data, ..., STOP
// and issues one write strobe per data byte. The pointer auto-increments
// and wraps at NUM_REGS-1.
//
// Ports:
//   clk, rst       system clock, asynchronous active-high reset
//   sda_in         synchronized SDA level, sampled on scl_rise_in
//   start_in       one-cycle START / repeated START event
//   stop_in        one-cycle STOP event
//   scl_rise_in    one-cycle SCL rising-edge event
//   scl_fall_in    one-cycle SCL falling-edge event
//   sda_low_out    1 = pull SDA low (ACK)
//   cfg_wr_out     one-cycle register write strobe
//   cfg_addr_out   register index of the write (held between strobes)
//   cfg_data_out   register data of the write (held between strobes)
//   busy_out       1 while a transaction is open
module i2c_cfg_slave #(
  parameter logic [6:0]  DEV_ADDR = 7'h48,
  parameter int unsigned NUM_REGS = 16,
  localparam int         RW       = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sda_in,
  input  logic          start_in,
  input  logic          stop_in,
  input  logic          scl_rise_in,
  input  logic          scl_fall_in,
  output logic          sda_low_out,
  output logic          cfg_wr_out,
  output logic [RW-1:0] cfg_addr_out,
  output logic [7:0]    cfg_data_out,
  output logic          busy_out
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, DATA, DATA_ACK, IGNORE
  } state_t;

  state_t        state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic [RW-1:0] ptr;
  logic          ack_pend;

  logic [7:0]    byte_next;
  logic          addr_ok;
  logic          ptr_ok;
  logic [RW-1:0] ptr_inc;

  assign byte_next = {shift[6:0], sda_in};
  assign addr_ok   = (shift[7:1] == DEV_ADDR) && !shift[0];
  assign ptr_ok    = ({24'd0, shift} < NUM_REGS);
  assign ptr_inc   = (ptr == RW'(NUM_REGS - 1)) ? '0 : ptr + RW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      shift        <= '0;
      ptr          <= '0;
      ack_pend     <= 1'b0;
      sda_low_out  <= 1'b0;
      cfg_wr_out   <= 1'b0;
      cfg_addr_out <= '0;
      cfg_data_out <= '0;
      busy_out     <= 1'b0;
    end else begin
      cfg_wr_out <= 1'b0;
      if (stop_in) begin
        state       <= IDLE;
        bit_cnt     <= '0;
        ack_pend    <= 1'b0;
        sda_low_out <= 1'b0;
        busy_out    <= 1'b0;
      end else if (start_in) begin
        // Pointer deliberately kept across repeated START.
        state       <= ADDR;
        bit_cnt     <= '0;
        ack_pend    <= 1'b0;
        sda_low_out <= 1'b0;
        busy_out    <= 1'b1;
      end else begin
        case (state)
          ADDR, PTR, DATA: begin
            if (scl_rise_in && !ack_pend) begin
              shift   <= byte_next;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                // Byte complete; hold the state until the SCL fall that
                // opens the ACK clock.
                ack_pend <= 1'b1;
                if (state == DATA) begin
                  cfg_wr_out   <= 1'b1;
                  cfg_addr_out <= ptr;
                  cfg_data_out <= byte_next;
                  ptr          <= ptr_inc;
                end
              end
            end else if (scl_fall_in && ack_pend) begin
              ack_pend <= 1'b0;
              case (state)
                ADDR: begin
                  state       <= ADDR_ACK;
                  sda_low_out <= addr_ok;
                end
                PTR: begin
                  state       <= PTR_ACK;
                  sda_low_out <= ptr_ok;
                  if (ptr_ok) ptr <= shift[RW-1:0];
                end
                default: begin
                  state       <= DATA_ACK;
                  sda_low_out <= 1'b1;
                end
              endcase
            end
          end
          ADDR_ACK, PTR_ACK, DATA_ACK: begin
            // sda_low_out doubles as the accept flag of the byte just acked.
            if (scl_fall_in) begin
              sda_low_out <= 1'b0;
              bit_cnt     <= '0;
              if (!sda_low_out)       state <= IGNORE;
              else if (state == ADDR_ACK) state <= PTR;
              else                    state <= DATA;
            end
          end
          default: ; // IDLE and IGNORE ignore SCL activity
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_cfg_slave.sv
// tb/tb_i2c_cfg_slave.sv - self-checking bench for i2c_cfg_slave
module tb_i2c_cfg_slave;

  logic       clk = 1'b0;
  logic       rst;
  logic       sda_in, start_in, stop_in, scl_rise_in, scl_fall_in;
  logic       sda_low_out, cfg_wr_out, busy_out;
  logic [3:0] cfg_addr_out;
  logic [7:0] cfg_data_out;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [11:0] wq[$];
  int          hi_cnt;

  i2c_cfg_slave #(.DEV_ADDR(7'h48), .NUM_REGS(16)) dut (
    .clk(clk), .rst(rst), .sda_in(sda_in), .start_in(start_in), .stop_in(stop_in),
    .scl_rise_in(scl_rise_in), .scl_fall_in(scl_fall_in), .sda_low_out(sda_low_out),
    .cfg_wr_out(cfg_wr_out), .cfg_addr_out(cfg_addr_out), .cfg_data_out(cfg_data_out),
    .busy_out(busy_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (cfg_wr_out) wq.push_back({cfg_addr_out, cfg_data_out});
    if (sda_low_out) hi_cnt++;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start;
    start_in = 1'b1; @(negedge clk); start_in = 1'b0;
  endtask

  task automatic pulse_stop;
    stop_in = 1'b1; @(negedge clk); stop_in = 1'b0;
  endtask

  task automatic pulse_rise;
    scl_rise_in = 1'b1; @(negedge clk); scl_rise_in = 1'b0;
  endtask

  task automatic pulse_fall;
    scl_fall_in = 1'b1; @(negedge clk); scl_fall_in = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] b, input int n, output logic wr_lsb);
    wr_lsb = 1'b0;
    for (int i = 7; i > 7 - n; i--) begin
      sda_in = b[i];
      pulse_rise;
      if (i == 0) wr_lsb = cfg_wr_out;
      idle(1);
      pulse_fall;
      idle(1);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack, output logic wr_lsb);
    send_bits(b, 8, wr_lsb);
    sda_in = 1'b1;
    pulse_rise;
    ack = sda_low_out;
    pulse_fall;
    idle(1);
  endtask

  typedef struct {
    logic [7:0] a, p, d;
    logic       ack_a, ack_p, ack_d;
    int         nwr;
    logic [3:0] waddr;
    logic [7:0] wdata;
  } vec_t;

  vec_t vecs[5];

  task automatic run_frame(input int k);
    logic aa, ap, ad, w0, w1, w2;
    string tag;
    tag = $sformatf("v%0d", k);
    wq.delete();
    hi_cnt = 0;
    pulse_start;
    chk({tag, " busy_after_start"}, busy_out, 1);
    send_byte(vecs[k].a, aa, w0);
    send_byte(vecs[k].p, ap, w1);
    send_byte(vecs[k].d, ad, w2);
    pulse_stop;
    chk({tag, " busy_after_stop"}, busy_out, 0);
    chk({tag, " sda_low_after_stop"}, sda_low_out, 0);
    chk({tag, " ack_addr"}, aa, vecs[k].ack_a);
    chk({tag, " ack_ptr"}, ap, vecs[k].ack_p);
    chk({tag, " ack_data"}, ad, vecs[k].ack_d);
    chk({tag, " wr_latency"}, w2, (vecs[k].nwr > 0) ? 1 : 0);
    chk({tag, " sda_ever_low"}, (hi_cnt != 0) ? 1 : 0,
        (vecs[k].ack_a | vecs[k].ack_p | vecs[k].ack_d) ? 1 : 0);
    chk({tag, " n_writes"}, wq.size(), vecs[k].nwr);
    if (vecs[k].nwr > 0 && wq.size() > 0)
      chk({tag, " write"}, wq[0], {vecs[k].waddr, vecs[k].wdata});
  endtask

  initial begin
    logic ack, wl;
    logic [11:0] exp_wrap [3];

    vecs[0] = '{8'h90, 8'h03, 8'hA5, 1, 1, 1, 1, 4'd3,  8'hA5};
    vecs[1] = '{8'h40, 8'h02, 8'h11, 0, 0, 0, 0, 4'd0,  8'h00};
    vecs[2] = '{8'h91, 8'h02, 8'h11, 0, 0, 0, 0, 4'd0,  8'h00};
    vecs[3] = '{8'h90, 8'h10, 8'h55, 1, 0, 0, 0, 4'd0,  8'h00};
    vecs[4] = '{8'h90, 8'h0F, 8'h7E, 1, 1, 1, 1, 4'd15, 8'h7E};

    sda_in = 1'b1; start_in = 1'b0; stop_in = 1'b0;
    scl_rise_in = 1'b0; scl_fall_in = 1'b0;
    rst = 1'b1;
    idle(3);
    chk("reset outputs", {sda_low_out, cfg_wr_out, busy_out, cfg_addr_out, cfg_data_out}, 0);
    rst = 1'b0;
    idle(2);

    // SCL activity in IDLE does nothing.
    wq.delete();
    send_byte(8'h90, ack, wl);
    chk("idle ack", ack, 0);
    chk("idle busy", busy_out, 0);

    for (int k = 0; k < 5; k++) run_frame(k);

    // Pointer wrap: writes to 14, 15, 0.
    exp_wrap = '{{4'd14, 8'h01}, {4'd15, 8'h02}, {4'd0, 8'h03}};
    wq.delete();
    pulse_start;
    send_byte(8'h90, ack, wl);
    send_byte(8'h0E, ack, wl);
    send_byte(8'h01, ack, wl);
    send_byte(8'h02, ack, wl);
    send_byte(8'h03, ack, wl);
    chk("wrap last ack", ack, 1);
    pulse_stop;
    chk("wrap n_writes", wq.size(), 3);
    for (int i = 0; i < 3 && i < wq.size(); i++)
      chk($sformatf("wrap write%0d", i), wq[i], exp_wrap[i]);

    // STOP after 5 data bits: no write, outputs hold the last write.
    wq.delete();
    pulse_start;
    send_byte(8'h90, ack, wl);
    send_byte(8'h05, ack, wl);
    send_bits(8'hFF, 5, wl);
    pulse_stop;
    idle(2);
    chk("midstop n_writes", wq.size(), 0);
    chk("midstop busy", busy_out, 0);
    chk("hold addr", cfg_addr_out, 0);
    chk("hold data", cfg_data_out, 8'h03);

    // Repeated START in the middle of a data byte, then a full frame.
    wq.delete();
    pulse_start;
    send_byte(8'h90, ack, wl);
    send_byte(8'h07, ack, wl);
    send_bits(8'hFF, 5, wl);
    pulse_start;
    chk("rstart busy", busy_out, 1);
    send_byte(8'h90, ack, wl);
    chk("rstart ack_addr", ack, 1);
    send_byte(8'h05, ack, wl);
    send_byte(8'h3C, ack, wl);
    pulse_stop;
    chk("rstart n_writes", wq.size(), 1);
    if (wq.size() > 0) chk("rstart write", wq[0], {4'd5, 8'h3C});

    // Async reset while ACKing the address byte.
    pulse_start;
    send_bits(8'h90, 8, wl);
    chk("pre-reset sda_low", sda_low_out, 1);
    #2 rst = 1'b1;
    #1;
    chk("async reset sda_low", sda_low_out, 0);
    chk("async reset busy", busy_out, 0);
    @(negedge clk);
    rst = 1'b0;
    sda_in = 1'b1;
    idle(2);
    run_frame(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
